// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: digit geometry
// and the active-low hex-to-cathode table, {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Control and display bus of the scan controller.
// The master drives value/load/enable; the slave drives the anode index and cathodes.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic         en;
  logic [31:0]  value_in;
  logic         load;
  logic         blank_lz;
  digit_t       digit_sel;
  logic [6:0]   seg;
  logic         commit;

  modport master (
    output en, value_in, load, blank_lz,
    input  digit_sel, seg, commit
  );

  modport slave (
    input  en, value_in, load, blank_lz,
    output digit_sel, seg, commit
  );

endinterface

// File: rtl/seg7_hex_enc.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit time-multiplexed scan controller with a tear-free display
// shadow register that only commits on frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int                CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam digit_t            IDX_LAST = digit_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_t           idx_q, idx_d;
  digit_t           digit_sel_q;
  logic [6:0]       seg_q, seg_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_reg_q, pend_reg_d;
  logic             pend_q, pend_d;
  logic             commit_evt_q, commit_evt_d;
  logic             commit_q;

  logic             tick;
  logic             frame_end;
  logic             lz_blank;
  logic [4:0]       nib_sh;
  logic [31:0]      upper;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg;

  assign nib_sh = {idx_q, 2'b00};
  assign nibble = disp_q[nib_sh +: 4];
  assign upper  = disp_q >> nib_sh;

  seg7_hex_enc u_hex_enc (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

  always_comb begin
    tick         = bus.en && (cnt_q == CNT_LAST);
    frame_end    = tick && (idx_q == IDX_LAST);
    lz_blank     = bus.blank_lz && (idx_q != '0) && (upper == '0);

    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_reg_d   = pend_reg_q;
    pend_d       = pend_q;
    commit_evt_d = 1'b0;

    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = idx_q + 1'b1;
    end

    // A load landing exactly on the boundary bypasses the shadow register.
    if (frame_end && bus.load) begin
      disp_d       = bus.value_in;
      pend_d       = 1'b0;
      commit_evt_d = 1'b1;
    end else if (frame_end && pend_q) begin
      disp_d       = pend_reg_q;
      pend_d       = 1'b0;
      commit_evt_d = 1'b1;
    end else if (bus.load) begin
      pend_reg_d   = bus.value_in;
      pend_d       = 1'b1;
    end

    seg_d = (!bus.en || lz_blank) ? SEG_BLANK : hex_seg;
  end

  // commit is delayed one stage so it lines up with the first digit-0 pattern.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      digit_sel_q  <= '0;
      seg_q        <= SEG_BLANK;
      disp_q       <= '0;
      pend_reg_q   <= '0;
      pend_q       <= 1'b0;
      commit_evt_q <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      digit_sel_q  <= idx_q;
      seg_q        <= seg_d;
      disp_q       <= disp_d;
      pend_reg_q   <= pend_reg_d;
      pend_q       <= pend_d;
      commit_evt_q <= commit_evt_d;
      commit_q     <= commit_evt_q;
    end
  end

  assign bus.digit_sel = digit_sel_q;
  assign bus.seg       = seg_q;
  assign bus.commit    = commit_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed corner sequences, a table
// of digit/segment vectors, and randomized traffic against a reference model.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] hex_tb [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: m_n is the number of enabled cycles into the current frame.
  int          m_n;
  logic [31:0] m_disp;
  logic [31:0] m_pendv;
  logic        m_pend;
  logic        m_cdel;
  logic        m_valid;
  logic [2:0]  exp_sel;
  logic [6:0]  exp_seg;
  logic        exp_commit;

  typedef struct {
    logic [31:0] value;
    logic        blank;
    int          digit;
    logic [6:0]  exp_seg;
  } vec_t;

  vec_t vecs [24];

  function automatic logic [6:0] ref_seg(input int d, input logic [31:0] v, input logic bl);
    logic [31:0] up;
    up = v >> (4 * d);
    if (bl && d != 0 && up == 0) return 7'h7F;
    return hex_tb[up[3:0]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int   oi;
    logic tk;
    if (!rstn) begin
      m_n = 0; m_disp = '0; m_pendv = '0; m_pend = 1'b0; m_cdel = 1'b0;
      exp_sel = '0; exp_seg = 7'h7F; exp_commit = 1'b0; m_valid = 1'b1;
    end else begin
      oi         = m_n / DIV;
      exp_sel    = 3'(oi);
      exp_seg    = bus.en ? ref_seg(oi, m_disp, bus.blank_lz) : 7'h7F;
      exp_commit = m_cdel;
      tk         = bus.en && ((m_n % DIV) == DIV - 1);
      m_cdel     = 1'b0;
      if (tk && oi == 7 && bus.load) begin
        m_disp = bus.value_in; m_pend = 1'b0; m_cdel = 1'b1;
      end else if (tk && oi == 7 && m_pend) begin
        m_disp = m_pendv; m_pend = 1'b0; m_cdel = 1'b1;
      end else if (bus.load) begin
        m_pendv = bus.value_in; m_pend = 1'b1;
      end
      if (bus.en) m_n = (m_n + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("model_sel", 32'(bus.digit_sel), 32'(exp_sel));
      chk("model_seg", 32'(bus.seg), 32'(exp_seg));
      chk("model_commit", 32'(bus.commit), 32'(exp_commit));
    end
  endtask

  task automatic wait_digit(input int d);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      if (int'(bus.digit_sel) == d) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_digit", 32'(found), 32'd1);
  endtask

  task automatic wait_commit();
    bit found;
    found = 1'b0;
    for (int k = 0; k < FRAME + 8; k++) begin
      step();
      if (bus.commit) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_commit", 32'(found), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.load = 1'b1;
    bus.value_in = v;
    step();
    bus.load = 1'b0;
  endtask

  task automatic count_commits(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.commit) c++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          c;
    logic [31:0] cur_val;

    checks = 0; errors = 0; m_valid = 1'b0;
    m_n = 0; m_disp = '0; m_pendv = '0; m_pend = 1'b0; m_cdel = 1'b0;

    for (int d = 0; d < 8; d++) begin
      vecs[d]      = '{32'h76543210, 1'b0, d, hex_tb[d]};
      vecs[8 + d]  = '{32'h00000105, 1'b1, d, 7'h7F};
      vecs[16 + d] = '{32'h00000105, 1'b0, d, 7'h40};
    end
    vecs[8]  = '{32'h00000105, 1'b1, 0, 7'h12};
    vecs[9]  = '{32'h00000105, 1'b1, 1, 7'h40};
    vecs[10] = '{32'h00000105, 1'b1, 2, 7'h79};
    vecs[16] = '{32'h00000105, 1'b0, 0, 7'h12};
    vecs[18] = '{32'h00000105, 1'b0, 2, 7'h79};

    // Reset for three cycles, then the first index change lands 5 edges later.
    rstn = 1'b0; bus.en = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.blank_lz = 1'b0;
    repeat (3) step();
    chk("reset_sel", 32'(bus.digit_sel), 32'd0);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    chk("reset_commit", 32'(bus.commit), 32'd0);
    rstn = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (bus.digit_sel == 3'd1) break;
    end
    chk("first_sel_change", 32'(n), 32'd5);

    // Scan order: every digit held DIV cycles, starting at the commit cycle.
    do_load(32'h76543210);
    wait_commit();
    chk("scan_commit_sel", 32'(bus.digit_sel), 32'd0);
    chk("scan_commit_seg", 32'(bus.seg), 32'h40);
    for (int j = 0; j < FRAME; j++) begin
      chk("scan_sel", 32'(bus.digit_sel), 32'(j / DIV));
      step();
    end

    // Tear-free load mid-frame; the later load wins.
    wait_digit(3);
    do_load(32'h12345678);
    step();
    do_load(32'h89ABCDEF);
    for (int k = 0; k < FRAME + 8; k++) begin
      step();
      if (bus.commit) break;
      chk("tearfree_old", 32'(bus.seg), 32'(hex_tb[bus.digit_sel]));
    end
    chk("tearfree_commit", 32'(bus.commit), 32'd1);
    chk("tearfree_sel", 32'(bus.digit_sel), 32'd0);
    chk("tearfree_seg", 32'(bus.seg), 32'h0E);
    count_commits(FRAME + 4, c);
    chk("tearfree_single", 32'(c), 32'd0);

    // Load coinciding with the frame boundary tick.
    for (int k = 0; k < FRAME + 2; k++) begin
      if (m_n == FRAME - 1) break;
      step();
    end
    do_load(32'h0000000A);
    step();
    chk("coinc_commit", 32'(bus.commit), 32'd1);
    chk("coinc_sel", 32'(bus.digit_sel), 32'd0);
    chk("coinc_seg", 32'(bus.seg), 32'h08);
    count_commits(FRAME + 4, c);
    chk("coinc_no_second", 32'(c), 32'd0);

    // Table of displayed value / blanking / digit -> cathode pattern.
    cur_val = 32'h0000000A;
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].value != cur_val) begin
        do_load(vecs[i].value);
        wait_commit();
        cur_val = vecs[i].value;
      end
      bus.blank_lz = vecs[i].blank;
      step();
      wait_digit(vecs[i].digit);
      chk("table_seg", 32'(bus.seg), 32'(vecs[i].exp_seg));
    end
    bus.blank_lz = 1'b0;

    // Enable drop at the first cycle of digit 5; the digit completes after resume.
    wait_digit(4);
    wait_digit(5);
    bus.en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("en_off_seg", 32'(bus.seg), 32'h7F);
      chk("en_off_sel", 32'(bus.digit_sel), 32'd5);
    end
    bus.en = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (bus.digit_sel == 3'd6) break;
    end
    chk("en_resume", 32'(n), 32'(DIV));

    // Reset with a pending value: it must never commit.
    wait_digit(2);
    do_load(32'hDEADBEEF);
    step();
    rstn = 1'b0;
    step();
    chk("rst_pend_sel", 32'(bus.digit_sel), 32'd0);
    chk("rst_pend_seg", 32'(bus.seg), 32'h7F);
    chk("rst_pend_commit", 32'(bus.commit), 32'd0);
    rstn = 1'b1;
    count_commits(3 * FRAME, c);
    chk("rst_pend_no_commit", 32'(c), 32'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      bus.en       = ($urandom % 10) != 0;
      bus.load     = ($urandom % 16) == 0;
      bus.value_in = $urandom >> ($urandom % 32);
      if (($urandom % 50) == 0) bus.blank_lz = ~bus.blank_lz;
      rstn         = ($urandom % 300) != 0;
      step();
    end
    rstn = 1'b1;
    bus.load = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
